// File: rtl/fetch_pkg.sv
// Shared definitions for the frame-BRAM to line-buffer fetch sequencer:
// FSM state encoding, default geometry and a width helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_MAX_ROW  = 540;
    localparam int unsigned DEF_MAX_COL  = 540;
    localparam int unsigned DEF_ADDR_W   = 19;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_RD_LAT   = 2;
    localparam int unsigned DEF_WIN_ROWS = 3;

    // Ceiling log2, never below 1 so that a single-entry field still has a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fetch_ctrl_rd_lat_pipe.sv
// Fixed-depth valid+tag delay line that lines up the line-buffer destination
// of each BRAM read with the data returning DEPTH cycles later.
module rd_lat_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             pending
);

    logic [DEPTH-1:0] vld;
    logic [TAG_W-1:0] tag [DEPTH];

    // Shift register; tags of empty slots are zeroed so idle outputs stay at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) tag[i] <= '0;
        end else if (flush) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) tag[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_valid ? in_tag : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    // Entries still queued behind the output stage (none left after this cycle when 0).
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | vld[i];
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: on each request, issues raster-order BRAM reads for the
// next window rows (WIN_ROWS on the first fetch of a frame, then one row),
// writes returned pixels into rotating line-buffer slots and pulses done.
// Optional macro FETCH_CKSUM_EN enables the per-fetch pixel checksum.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_ROW  = DEF_MAX_ROW,
    parameter int unsigned MAX_COL  = DEF_MAX_COL,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RD_LAT   = DEF_RD_LAT,
    parameter int unsigned WIN_ROWS = DEF_WIN_ROWS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_run_i,
    input  logic                         frame_rst_i,
    output logic                         bram_en_o,
    output logic [ADDR_W-1:0]            bram_addr_o,
    input  logic [DATA_W-1:0]            bram_rdata_i,
    input  logic                         buf_ready_i,
    output logic                         buf_we_o,
    output logic [DATA_W-1:0]            buf_wdata_o,
    output logic [clog2(WIN_ROWS)-1:0]   buf_slot_o,
    output logic [clog2(MAX_COL)-1:0]    buf_col_o,
    output logic                         fetch_done_o,
    output logic                         frame_last_o,
    output logic                         busy_o,
    output logic [15:0]                  cksum_o
);

    localparam int unsigned COL_W  = clog2(MAX_COL);
    localparam int unsigned SLOT_W = clog2(WIN_ROWS);
    localparam int unsigned ROW_W  = clog2(MAX_ROW + 1);
    localparam int unsigned TAG_W  = SLOT_W + COL_W;

    state_t              state, state_nx;
    logic [ROW_W-1:0]    row_ptr, rows_left, rows_init;
    logic [ADDR_W-1:0]   row_base;
    logic [COL_W-1:0]    col;
    logic [SLOT_W-1:0]   slot;
    logic                frame_last;
    logic                start, issue, col_end, last_issue;
    logic                pipe_valid, pipe_pending;
    logic [TAG_W-1:0]    pipe_tag;
    logic [31:0]         remaining, want;

    assign start      = (state == S_IDLE) && !frame_rst_i && fetch_run_i && !frame_last;
    assign issue      = (state == S_ISSUE) && buf_ready_i;
    assign col_end    = (col == COL_W'(MAX_COL - 1));
    assign last_issue = issue && col_end && (rows_left == ROW_W'(1));

    // Rows for this fetch: full window at frame start, else one, clipped at the frame end.
    always_comb begin
        remaining = MAX_ROW - 32'(row_ptr);
        want      = (row_ptr == '0) ? WIN_ROWS : 32'd1;
        rows_init = ROW_W'((want < remaining) ? want : remaining);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ISSUE;
            S_ISSUE: if (last_issue) state_nx = S_DRAIN;
            S_DRAIN: if (!pipe_pending) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Raster position: column stepping, row base by repeated addition, slot rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ptr    <= '0;
            rows_left  <= '0;
            row_base   <= '0;
            col        <= '0;
            slot       <= '0;
            frame_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_rst_i) begin
                        row_ptr    <= '0;
                        row_base   <= '0;
                        slot       <= '0;
                        frame_last <= 1'b0;
                    end else if (start) begin
                        rows_left <= rows_init;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        if (col_end) begin
                            col       <= '0;
                            row_base  <= row_base + ADDR_W'(MAX_COL);
                            row_ptr   <= row_ptr + 1'b1;
                            rows_left <= rows_left - 1'b1;
                            slot      <= (slot == SLOT_W'(WIN_ROWS - 1)) ? '0 : slot + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pipe_pending && (row_ptr == ROW_W'(MAX_ROW))) frame_last <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Rewinding a frame also clears the pipe (it is already empty in idle).
    rd_lat_pipe #(
        .DEPTH (RD_LAT),
        .TAG_W (TAG_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     ((state == S_IDLE) && frame_rst_i),
        .in_valid  (issue),
        .in_tag    ({slot, col}),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .pending   (pipe_pending)
    );

    assign bram_en_o    = issue;
    assign bram_addr_o  = row_base + ADDR_W'(col);
    assign buf_we_o     = pipe_valid;
    assign buf_wdata_o  = pipe_valid ? bram_rdata_i : '0;
    assign buf_slot_o   = pipe_tag[TAG_W-1:COL_W];
    assign buf_col_o    = pipe_tag[COL_W-1:0];
    assign fetch_done_o = (state == S_DONE);
    assign frame_last_o = frame_last;
    assign busy_o       = (state != S_IDLE);

`ifdef FETCH_CKSUM_EN
    logic [15:0] cksum;

    // Wrapping sum of pixels written during the current fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cksum <= '0;
        else if (start)    cksum <= '0;
        else if (buf_we_o) cksum <= cksum + 16'(buf_wdata_o);
    end

    assign cksum_o = cksum;
`else
    assign cksum_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a row/column reference model queues the
// expected reads, writes and completions; a negedge monitor pops and compares.
module tb_fetch_ctrl;

    localparam int unsigned MAX_ROW  = 4;
    localparam int unsigned MAX_COL  = 5;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned WIN_ROWS = 3;
    localparam int unsigned SLOT_W   = fetch_pkg::clog2(WIN_ROWS);
    localparam int unsigned COL_W    = fetch_pkg::clog2(MAX_COL);
`ifdef FETCH_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_run = 1'b0;
    logic              frame_rst = 1'b0;
    logic              buf_ready = 1'b1;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_rdata;
    logic              buf_we;
    logic [DATA_W-1:0] buf_wdata;
    logic [SLOT_W-1:0] buf_slot;
    logic [COL_W-1:0]  buf_col;
    logic              fetch_done;
    logic              frame_last;
    logic              busy;
    logic [15:0]       cksum;

    fetch_ctrl #(
        .MAX_ROW  (MAX_ROW),
        .MAX_COL  (MAX_COL),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .WIN_ROWS (WIN_ROWS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_run_i  (fetch_run),
        .frame_rst_i  (frame_rst),
        .bram_en_o    (bram_en),
        .bram_addr_o  (bram_addr),
        .bram_rdata_i (bram_rdata),
        .buf_ready_i  (buf_ready),
        .buf_we_o     (buf_we),
        .buf_wdata_o  (buf_wdata),
        .buf_slot_o   (buf_slot),
        .buf_col_o    (buf_col),
        .fetch_done_o (fetch_done),
        .frame_last_o (frame_last),
        .busy_o       (busy),
        .cksum_o      (cksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // BRAM content: low address byte xor a per-fetch key.
    logic [7:0] key = 8'd0;
    function automatic logic [7:0] data_of(input longint a, input logic [7:0] k);
        return 8'(a) ^ k;
    endfunction

    // Behavioural BRAM: data appears RD_LAT cycles after the read.
    logic [ADDR_W-1:0] ad [RD_LAT] = '{default: '0};
    always @(posedge clk) begin
        ad[0] <= bram_addr;
        for (int i = 1; i < RD_LAT; i++) ad[i] <= ad[i-1];
    end
    assign bram_rdata = data_of(ad[RD_LAT-1], key);

    typedef struct { int unsigned slot; int unsigned col; int unsigned data; } wr_t;
    typedef struct { int unsigned last; int unsigned sum; } done_t;
    int unsigned exp_addr[$];
    wr_t         exp_wr[$];
    done_t       exp_done[$];

    int unsigned m_row = 0;
    bit          m_last = 1'b0;

    function automatic void model_fetch();
        int unsigned rows, sum, a, d;
        if (m_last) return;
        rows = (m_row == 0) ? WIN_ROWS : 1;
        if (rows > MAX_ROW - m_row) rows = MAX_ROW - m_row;
        sum = 0;
        for (int unsigned r = m_row; r < m_row + rows; r++) begin
            for (int unsigned c = 0; c < MAX_COL; c++) begin
                a = r * MAX_COL + c;
                d = data_of(a, key);
                exp_addr.push_back(a);
                exp_wr.push_back('{r % WIN_ROWS, c, d});
                sum = (sum + d) % 65536;
            end
        end
        m_row  = m_row + rows;
        m_last = (m_row == MAX_ROW);
        exp_done.push_back('{m_last, CK ? sum : 0});
    endfunction

    function automatic void model_clear();
        exp_addr.delete();
        exp_wr.delete();
        exp_done.delete();
    endfunction

    int unsigned cyc = 0;
    int unsigned last_issue_cyc = 0;
    wr_t   mw;
    done_t md;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every DUT event against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!buf_ready) check("en_while_stalled", bram_en, 0);
            if (!buf_ready && busy && exp_addr.size() > 0) check("addr_hold", bram_addr, exp_addr[0]);
            if (buf_ready && busy && exp_addr.size() > 0) check("issue_when_ready", bram_en, 1);
            if (bram_en) begin
                if (exp_addr.size() == 0) check("unexpected_issue", bram_en, 0);
                else begin
                    check("issue_addr", bram_addr, exp_addr.pop_front());
                    last_issue_cyc = cyc;
                end
            end
            if (buf_we) begin
                if (exp_wr.size() == 0) check("unexpected_write", buf_we, 0);
                else begin
                    mw = exp_wr.pop_front();
                    check("write_slot", buf_slot, mw.slot);
                    check("write_col", buf_col, mw.col);
                    check("write_data", buf_wdata, mw.data);
                end
            end
            if (fetch_done) begin
                if (exp_done.size() == 0) check("unexpected_done", fetch_done, 0);
                else begin
                    md = exp_done.pop_front();
                    check("done_latency", cyc - last_issue_cyc, RD_LAT + 1);
                    check("done_frame_last", frame_last, md.last);
                    check("done_cksum", cksum, md.sum);
                    check("done_queues_empty", exp_wr.size() + exp_addr.size(), 0);
                end
            end
        end
    end

    task automatic fetch_pulse();
        @(posedge clk); #1 fetch_run = 1'b1; model_fetch();
        @(posedge clk); #1 fetch_run = 1'b0;
    endtask

    task automatic frame_rst_pulse();
        @(posedge clk); #1 frame_rst = 1'b1; m_row = 0; m_last = 1'b0;
        @(posedge clk); #1 frame_rst = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        n = 0;
        while (exp_done.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            if (rnd) begin
                buf_ready = ($urandom_range(3) != 0);
                fetch_run = busy && ($urandom_range(7) == 0);
                frame_rst = busy && ($urandom_range(7) == 0);
            end
            n++;
        end
        if (exp_done.size() > 0) begin
            check("done_timeout", exp_done.size(), 0);
            model_clear();
        end
        fetch_run = 1'b0;
        frame_rst = 1'b0;
        buf_ready = 1'b1;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_en"}, bram_en, 0);
        check({tag, "_addr"}, bram_addr, 0);
        check({tag, "_we"}, buf_we, 0);
        check({tag, "_wdata"}, buf_wdata, 0);
        check({tag, "_slot"}, buf_slot, 0);
        check({tag, "_col"}, buf_col, 0);
        check({tag, "_done"}, fetch_done, 0);
        check({tag, "_last"}, frame_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cksum"}, cksum, 0);
    endtask

    initial begin
        int n;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // First fetch of a frame: three rows; checksum of 0..14 is 105.
        frame_rst_pulse();
        fetch_pulse();
        wait_done(1'b0);
        check("first_last_level", frame_last, 0);
        check("first_cksum", cksum, CK ? 105 : 0);

        // Second fetch: final row, frame complete.
        fetch_pulse();
        wait_done(1'b0);
        check("second_last_level", frame_last, 1);

        // Request after the frame end is ignored.
        fetch_pulse();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("ignored_busy", busy, 0);
            check("ignored_done", fetch_done, 0);
        end

        // Rewind and request together: rewind wins, nothing starts.
        @(posedge clk); #1 frame_rst = 1'b1; fetch_run = 1'b1; m_row = 0; m_last = 1'b0;
        @(posedge clk); #1 frame_rst = 1'b0; fetch_run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_run_busy", busy, 0);
        end
        check("rst_run_last", frame_last, 0);

        // Back-pressure for three cycles after address 2.
        frame_rst_pulse();
        fetch_pulse();
        n = 0;
        do begin @(negedge clk); n++; end while (!(bram_en && bram_addr == 2) && n < 100);
        if (n >= 100) check("reach_addr2", bram_addr, 2);
        @(posedge clk); #1 buf_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 buf_ready = 1'b1;
        wait_done(1'b0);

        // Reset while issuing address 7.
        frame_rst_pulse();
        fetch_pulse();
        n = 0;
        do begin @(negedge clk); n++; end while (!(bram_en && bram_addr == 7) && n < 100);
        if (n >= 100) check("reach_addr7", bram_addr, 7);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        model_clear();
        m_row = 0;
        m_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset_no_write", buf_we, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        fetch_pulse();
        wait_done(1'b0);

        // Randomised fetches with random data, back-pressure and ignored pulses.
        for (int i = 0; i < 16; i++) begin
            key = 8'($urandom);
            if ($urandom_range(3) == 0 || m_last) frame_rst_pulse();
            fetch_pulse();
            wait_done(1'b1);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", checks);
        $fatal(1, "global timeout");
    end

endmodule
